pipe_flush_ctrl: RTL and testbench

- Parametrised pipeline flush/stall controller for the CPU core.
- Generalises single-bit jump clear into:
  - per-stage clear and stall masks;
  - multi-cycle flush windows;
  - load-use bubble insertion;
  - memory-busy freeze with a deferred pending jump.
- Sits beside the PC unit; drives clear/stall inputs of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB, ...).

---
 rtl/pipe_flush_ctrl.sv | 84 ++++++++
 tb/tb_pipe_flush_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pipe_flush_ctrl.sv
// pipe_flush_ctrl: per-stage clear/stall controller with flush windows, load-use bubbles and memory freeze.
// Optional performance counters are enabled by defining PIPE_FLUSH_CTRL_PERF_EN.
module pipe_flush_ctrl #(
  parameter int STAGES       = 5,
  parameter int JUMP_STAGE   = 2,
  parameter int HAZ_STAGE    = 2,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_jump_en,
  input  logic              stall_req,
  input  logic              mem_busy,
  output logic [STAGES-1:0] clear,
  output logic [STAGES-1:0] stall,
  output logic              pc_hold,
  output logic              busy
`ifdef PIPE_FLUSH_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_flush_cnt,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_freeze_cnt
`endif
);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [STAGES-1:0] ONES  = '1;
  localparam logic [STAGES-1:0] JMASK = ONES >> (STAGES - JUMP_STAGE);
  localparam logic [STAGES-1:0] HMASK = ONES >> (STAGES - HAZ_STAGE);
  localparam logic [STAGES-1:0] HBIT  = (ONES >> (STAGES - 1)) << HAZ_STAGE;
  localparam logic [CW-1:0] RELOAD = CW'(FLUSH_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, FLUSH, FREEZE} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d;
  logic freeze, jmp, flushing, bubble;
  always_comb begin
    freeze   = !rst && mem_busy;
    jmp      = !rst && !mem_busy && (pc_jump_en || (state_q == FREEZE && pend_q));
    flushing = jmp || (!rst && !mem_busy && state_q == FLUSH);
    bubble   = !rst && !mem_busy && !flushing && stall_req;
    clear    = flushing ? JMASK : bubble ? HBIT : '0;
    stall    = freeze ? ONES : bubble ? HMASK : '0;
    pc_hold  = freeze || bubble;
    busy     = !rst && state_q != IDLE;
    state_d  = IDLE;
    cnt_d    = cnt_q;
    pend_d   = 1'b0;
    // a freeze interrupting a flush defers it as a pending jump that reloads the full window
    if (freeze) begin
      state_d = FREEZE;
      pend_d  = pend_q || pc_jump_en || state_q == FLUSH;
    end else if (jmp) begin
      cnt_d   = RELOAD;
      state_d = FLUSH_CYCLES > 1 ? FLUSH : IDLE;
    end else if (flushing) begin
      cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
      state_d = cnt_d == '0 ? IDLE : FLUSH;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end
`ifdef PIPE_FLUSH_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_flush_cnt  <= '0;
      perf_stall_cnt  <= '0;
      perf_freeze_cnt <= '0;
    end else begin
      perf_flush_cnt  <= perf_flush_cnt + {31'b0, |clear};
      perf_stall_cnt  <= perf_stall_cnt + {31'b0, bubble};
      perf_freeze_cnt <= perf_freeze_cnt + {31'b0, freeze};
    end
  end
`endif
endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// tb_pipe_flush_ctrl: checks two controller instances (FLUSH_CYCLES 1 and 3) against a cycle-count reference model.
module tb_pipe_flush_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1, pc_jump_en = 1'b0, stall_req = 1'b0, mem_busy = 1'b0;
  logic [4:0] clear0, stall0, clear3, stall3;
  logic ph0, b0, ph3, b3;
`ifdef PIPE_FLUSH_CTRL_PERF_EN
  logic [31:0] pf0, ps0, pz0, pf3, ps3, pz3;
`endif
  int tests = 0, fails = 0;
  int fl[2];
  bit dfr[2], frz[2];
  int unsigned cf[2], cs[2], cz[2];

  always #5 clk = ~clk;

  pipe_flush_ctrl #(.FLUSH_CYCLES(1)) u0 (
    .clk(clk), .rst(rst), .pc_jump_en(pc_jump_en), .stall_req(stall_req), .mem_busy(mem_busy),
    .clear(clear0), .stall(stall0), .pc_hold(ph0), .busy(b0)
`ifdef PIPE_FLUSH_CTRL_PERF_EN
    , .perf_flush_cnt(pf0), .perf_stall_cnt(ps0), .perf_freeze_cnt(pz0)
`endif
  );
  pipe_flush_ctrl #(.FLUSH_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .pc_jump_en(pc_jump_en), .stall_req(stall_req), .mem_busy(mem_busy),
    .clear(clear3), .stall(stall3), .pc_hold(ph3), .busy(b3)
`ifdef PIPE_FLUSH_CTRL_PERF_EN
    , .perf_flush_cnt(pf3), .perf_stall_cnt(ps3), .perf_freeze_cnt(pz3)
`endif
  );

  task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s fc%0d at %0t: got %0h expected %0h", tag, k ? 3 : 1, $time, got, exp);
    end
  endtask

  // Model: fl = clearing cycles still owed, dfr = jump deferred by a freeze, frz = frozen last cycle.
  task automatic cyc(input bit r, input bit j, input bit s, input bit m);
    logic [4:0] ec, es;
    bit eph, eb, bub;
    int f, nfl;
    bit ndfr, nfrz;
    int nf[2], nd[2];
    bit ndf[2], nfz[2];
    rst = r; pc_jump_en = j; stall_req = s; mem_busy = m;
    #2;
    for (int k = 0; k < 2; k++) begin
      ec = '0; es = '0; eph = 0; bub = 0;
      eb = !r && (frz[k] || fl[k] > 0);
      nfl = 0; ndfr = 0; nfrz = 0;
      if (r) begin
        nfl = 0;
      end else if (m) begin
        es = 5'b11111; eph = 1;
        ndfr = dfr[k] || j || fl[k] > 0;
        nfrz = 1;
        nfl = fl[k];
      end else begin
        f = (j || dfr[k]) ? (k ? 3 : 1) : fl[k];
        if (f > 0) begin
          ec = 5'b00011;
          nfl = f - 1;
        end else if (s) begin
          es = 5'b00011; ec = 5'b00100; eph = 1; bub = 1;
        end
      end
      chk("clear", k, 32'(k ? clear3 : clear0), 32'(ec));
      chk("stall", k, 32'(k ? stall3 : stall0), 32'(es));
      chk("pc_hold", k, 32'(k ? ph3 : ph0), 32'(eph));
      chk("busy", k, 32'(k ? b3 : b0), 32'(eb));
`ifdef PIPE_FLUSH_CTRL_PERF_EN
      if (!r) begin
        chk("perf_flush", k, k ? pf3 : pf0, cf[k]);
        chk("perf_stall", k, k ? ps3 : ps0, cs[k]);
        chk("perf_freeze", k, k ? pz3 : pz0, cz[k]);
      end
`endif
      nf[k] = nfl; ndf[k] = ndfr; nfz[k] = nfrz;
      nd[k] = bub;
      if (r) begin
        cf[k] = 0; cs[k] = 0; cz[k] = 0;
      end else begin
        cf[k] += (ec != 0) ? 1 : 0;
        cs[k] += bub ? 1 : 0;
        cz[k] += m ? 1 : 0;
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      fl[k] = nf[k]; dfr[k] = ndf[k]; frz[k] = nfz[k];
    end
    #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      fl[k] = 0; dfr[k] = 0; frz[k] = 0; cf[k] = 0; cs[k] = 0; cz[k] = 0;
    end
    @(posedge clk); #1;
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 1);
    cyc(0, 0, 0, 0);
    // single jump, then idle
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    // back-to-back jumps extend the window
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 1, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    // load-use bubble, then bubble colliding with a jump
    cyc(0, 0, 1, 0); cyc(0, 0, 0, 0); cyc(0, 1, 1, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    // freeze for four cycles with a jump arriving mid-freeze
    cyc(0, 0, 0, 1); cyc(0, 1, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    // freeze interrupting a flush, then release
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    // reset abandons flush and pending jump
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 1); cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);
    for (int n = 0; n < 600; n++)
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 5) < 2);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
